fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: BOOT/RUN/HALT sequencer feeding the IF/ID register.
// Redirects flush IF/ID and restart fetch; misaligned targets raise a sticky flag.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PROG_END = 32'd28
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        halted,
  output logic        misalign
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_inc;
  logic        capture, valid_nxt;

  assign imem_addr = pc;
  assign halted    = (state == HALT);
  assign pc_inc    = pc + 32'd4;

  // Decode back-pressure only blocks capture while a word is still held.
  assign capture = (state == RUN) && !redirect
                && (!id_valid || id_ready);

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = RUN;
    end else begin
      unique case (state)
        BOOT:    state_nxt = RUN;
        RUN:     if (capture && pc == PROG_END)
                   state_nxt = HALT;
        HALT:    state_nxt = HALT;
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_comb begin
    pc_nxt    = pc;
    valid_nxt = id_valid;
    if (redirect) begin
      pc_nxt    = {redirect_pc[31:2], 2'b00};
      valid_nxt = 1'b0;
    end else if (capture) begin
      pc_nxt    = pc_inc;
      valid_nxt = 1'b1;
    end else if (id_ready) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= 32'd0;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd0;
      misalign    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      id_valid <= valid_nxt;
      if (capture) begin
        id_instr    <= imem_instr;
        id_pc       <= pc;
        id_pc_plus4 <= pc_inc;
      end
      if (redirect && redirect_pc[1:0] != 2'b00)
        misalign <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a per-cycle reference model
// queues expected IF/ID snapshots, a negedge monitor compares them.
module tb_fetch_unit;

  localparam logic [31:0] PEND = 32'd28;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        halted;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .PROG_END(PEND)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .id_ready(id_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .halted(halted),
    .misalign(misalign)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[17:2]};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] p4;
    logic        halted;
    logic        mis;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];

  // Reference: "mode" 0=booting, 1=fetching, 2=stopped.
  int          m_mode;
  logic [31:0] m_next;
  logic        m_valid, m_mis;
  logic [31:0] m_instr, m_pc, m_p4;

  task automatic model_step(input logic r, input logic rdy,
                            input logic red, input logic [31:0] tgt);
    if (r) begin
      m_mode = 0; m_next = 32'h0; m_valid = 0; m_mis = 0;
      m_instr = 0; m_pc = 0; m_p4 = 0;
    end else if (red) begin
      m_mode  = 1;
      m_next  = tgt & 32'hFFFF_FFFC;
      m_valid = 0;
      if (tgt % 4 != 0) m_mis = 1;
    end else if (m_mode == 1 && (!m_valid || rdy)) begin
      m_instr = mem_word(m_next);
      m_pc    = m_next;
      m_p4    = m_next + 32'd4;
      m_valid = 1;
      if (m_next == PEND) m_mode = 2;
      m_next  = m_next + 32'd4;
    end else begin
      if (rdy) m_valid = 0;
      if (m_mode == 0) m_mode = 1;
    end
  endtask

  task automatic apply(input logic r, input logic rdy,
                       input logic red, input logic [31:0] tgt);
    exp_t e;
    rst = r; id_ready = rdy; redirect = red; redirect_pc = tgt;
    @(posedge clk);
    model_step(r, rdy, red, tgt);
    e.valid  = m_valid; e.instr = m_instr; e.pc = m_pc;
    e.p4     = m_p4;    e.halted = (m_mode == 2);
    e.mis    = m_mis;   e.addr = m_next;
    q.push_back(e);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
        chk("id_instr", id_instr, e.instr);
        chk("id_pc", id_pc, e.pc);
        chk("id_pc_plus4", id_pc_plus4, e.p4);
        chk("halted", {31'd0, halted}, {31'd0, e.halted});
        chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
        chk("imem_addr", imem_addr, e.addr);
      end
    end
  end

  initial begin : stim
    logic [31:0] tgt;
    rst = 1; id_ready = 0; redirect = 0; redirect_pc = 0;
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    for (int i = 0; i < 14; i++) apply(0, 1, 0, 0);
    apply(0, 1, 1, 32'h0);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0);
    apply(0, 1, 1, 32'd4);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0);
    apply(0, 1, 1, 32'h0000_0013);
    for (int i = 0; i < 10; i++) apply(0, 1, 0, 0);
    apply(0, 1, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0);
    apply(0, 0, 0, 0);
    apply(1, 0, 1, 32'd8);
    apply(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        tgt = 32'($urandom_range(0, 40));
      apply($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, tgt);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
